// File: rtl/reservation_station_if.sv
// Decoder issue port, ALU/LSB result broadcasts and ALU dispatch port of the reservation station.
interface reservation_station_if #(
    parameter int DATA_W    = 32,
    parameter int ROB_POS_W = 4
);
    logic                 rs_full;

    logic                 issue;
    logic [6:0]           issue_opcode;
    logic [2:0]           issue_func3;
    logic                 issue_func1;
    logic [DATA_W-1:0]    issue_rs1_val;
    logic [ROB_POS_W:0]   issue_rs1_rob_id;
    logic [DATA_W-1:0]    issue_rs2_val;
    logic [ROB_POS_W:0]   issue_rs2_rob_id;
    logic [DATA_W-1:0]    issue_imm;
    logic [DATA_W-1:0]    issue_pc;
    logic [ROB_POS_W-1:0] issue_rob_pos;

    logic                 alu_result;
    logic [ROB_POS_W-1:0] alu_result_rob_pos;
    logic [DATA_W-1:0]    alu_result_val;
    logic                 lsb_result;
    logic [ROB_POS_W-1:0] lsb_result_rob_pos;
    logic [DATA_W-1:0]    lsb_result_val;

    logic                 alu_en;
    logic [6:0]           alu_opcode;
    logic [2:0]           alu_func3;
    logic                 alu_func1;
    logic [DATA_W-1:0]    alu_val1;
    logic [DATA_W-1:0]    alu_val2;
    logic [DATA_W-1:0]    alu_imm;
    logic [DATA_W-1:0]    alu_pc;
    logic [ROB_POS_W-1:0] alu_rob_pos;

    modport master (
        input  rs_full,
        output issue, issue_opcode, issue_func3, issue_func1,
               issue_rs1_val, issue_rs1_rob_id, issue_rs2_val, issue_rs2_rob_id,
               issue_imm, issue_pc, issue_rob_pos,
        output alu_result, alu_result_rob_pos, alu_result_val,
               lsb_result, lsb_result_rob_pos, lsb_result_val,
        input  alu_en, alu_opcode, alu_func3, alu_func1,
               alu_val1, alu_val2, alu_imm, alu_pc, alu_rob_pos
    );

    modport slave (
        output rs_full,
        input  issue, issue_opcode, issue_func3, issue_func1,
               issue_rs1_val, issue_rs1_rob_id, issue_rs2_val, issue_rs2_rob_id,
               issue_imm, issue_pc, issue_rob_pos,
        input  alu_result, alu_result_rob_pos, alu_result_val,
               lsb_result, lsb_result_rob_pos, lsb_result_val,
        output alu_en, alu_opcode, alu_func3, alu_func1,
               alu_val1, alu_val2, alu_imm, alu_pc, alu_rob_pos
    );
endinterface

// File: rtl/reservation_station.sv
// Reservation station: buffers non-memory instructions until both operands resolve, snoops
// ALU/LSB broadcasts, and dispatches the lowest-index ready entry to the ALU each cycle.
module reservation_station #(
    parameter int RS_SIZE    = 16,
    parameter int RS_POS_WID = 4,
    parameter int DATA_W     = 32,
    parameter int ROB_POS_W  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                rollback,
    reservation_station_if.slave rs
);
    typedef struct packed {
        logic [ROB_POS_W:0]  rob_id;
        logic [DATA_W-1:0]   val;
    } opnd_t;

    typedef struct packed {
        logic                 vld;
        logic [ROB_POS_W-1:0] pos;
        logic [DATA_W-1:0]    val;
    } bcast_t;

    localparam logic [RS_POS_WID:0] FULL_MARK = (RS_POS_WID+1)'(RS_SIZE - 1);

    // ALU broadcast is checked first so it wins when both units report the same position.
    function automatic opnd_t snoop(input opnd_t op, input bcast_t alu_bc, input bcast_t lsb_bc);
        opnd_t res;
        res = op;
        if (op.rob_id[ROB_POS_W]) begin
            if (alu_bc.vld && alu_bc.pos == op.rob_id[ROB_POS_W-1:0]) begin
                res.rob_id = '0;
                res.val    = alu_bc.val;
            end else if (lsb_bc.vld && lsb_bc.pos == op.rob_id[ROB_POS_W-1:0]) begin
                res.rob_id = '0;
                res.val    = lsb_bc.val;
            end
        end
        return res;
    endfunction

    logic [RS_SIZE-1:0]   busy;
    logic [6:0]           ent_opcode  [RS_SIZE];
    logic [2:0]           ent_func3   [RS_SIZE];
    logic                 ent_func1   [RS_SIZE];
    logic [DATA_W-1:0]    ent_imm     [RS_SIZE];
    logic [DATA_W-1:0]    ent_pc      [RS_SIZE];
    logic [ROB_POS_W-1:0] ent_rob_pos [RS_SIZE];
    opnd_t                ent_op1     [RS_SIZE];
    opnd_t                ent_op2     [RS_SIZE];

    bcast_t               alu_bc, lsb_bc;
    logic [RS_SIZE-1:0]   ready_p0;
    logic                 sel_vld_p0;
    logic [RS_POS_WID-1:0] sel_idx_p0;
    logic                 free_vld_p0;
    logic [RS_POS_WID-1:0] free_idx_p0;
    logic                 issue_ok_p0;
    opnd_t                op1_nxt [RS_SIZE];
    opnd_t                op2_nxt [RS_SIZE];
    logic [RS_SIZE-1:0]   busy_nxt;
    logic [RS_POS_WID:0]  cnt_nxt;

    logic                 rs_full_p1;
    logic                 vld_p1;
    logic [6:0]           opcode_p1;
    logic [2:0]           func3_p1;
    logic                 func1_p1;
    logic [DATA_W-1:0]    val1_p1, val2_p1, imm_p1, pc_p1;
    logic [ROB_POS_W-1:0] rob_pos_p1;

    assign alu_bc      = '{vld: rs.alu_result, pos: rs.alu_result_rob_pos, val: rs.alu_result_val};
    assign lsb_bc      = '{vld: rs.lsb_result, pos: rs.lsb_result_rob_pos, val: rs.lsb_result_val};
    assign issue_ok_p0 = rs.issue && free_vld_p0;

    // Stage p0: select lowest ready entry and lowest free slot from cycle-start state
    always_comb begin
        ready_p0    = '0;
        sel_vld_p0  = 1'b0;
        sel_idx_p0  = '0;
        free_vld_p0 = 1'b0;
        free_idx_p0 = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            ready_p0[i] = busy[i] && (ent_op1[i].rob_id == '0) && (ent_op2[i].rob_id == '0);
            if (ready_p0[i]) begin
                sel_vld_p0 = 1'b1;
                sel_idx_p0 = RS_POS_WID'(i);
            end
            if (!busy[i]) begin
                free_vld_p0 = 1'b1;
                free_idx_p0 = RS_POS_WID'(i);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            op1_nxt[i] = snoop(ent_op1[i], alu_bc, lsb_bc);
            op2_nxt[i] = snoop(ent_op2[i], alu_bc, lsb_bc);
        end
        if (issue_ok_p0) begin
            op1_nxt[free_idx_p0] = snoop(opnd_t'({rs.issue_rs1_rob_id, rs.issue_rs1_val}), alu_bc, lsb_bc);
            op2_nxt[free_idx_p0] = snoop(opnd_t'({rs.issue_rs2_rob_id, rs.issue_rs2_val}), alu_bc, lsb_bc);
        end
    end

    // A slot freed by dispatch this cycle is only offered to issue next cycle.
    always_comb begin
        busy_nxt = busy;
        if (sel_vld_p0) busy_nxt[sel_idx_p0] = 1'b0;
        if (issue_ok_p0) busy_nxt[free_idx_p0] = 1'b1;
        cnt_nxt = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            cnt_nxt = cnt_nxt + {{RS_POS_WID{1'b0}}, busy_nxt[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (rdy && !rollback) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                ent_op1[i] <= op1_nxt[i];
                ent_op2[i] <= op2_nxt[i];
            end
            if (issue_ok_p0) begin
                ent_opcode[free_idx_p0]  <= rs.issue_opcode;
                ent_func3[free_idx_p0]   <= rs.issue_func3;
                ent_func1[free_idx_p0]   <= rs.issue_func1;
                ent_imm[free_idx_p0]     <= rs.issue_imm;
                ent_pc[free_idx_p0]      <= rs.issue_pc;
                ent_rob_pos[free_idx_p0] <= rs.issue_rob_pos;
            end
        end
    end

    // Stage p1: registered dispatch port and occupancy flag
    always_ff @(posedge clk) begin
        if (rst) begin
            busy       <= '0;
            rs_full_p1 <= 1'b0;
            vld_p1     <= 1'b0;
            opcode_p1  <= '0;
            func3_p1   <= '0;
            func1_p1   <= 1'b0;
            val1_p1    <= '0;
            val2_p1    <= '0;
            imm_p1     <= '0;
            pc_p1      <= '0;
            rob_pos_p1 <= '0;
        end else if (rdy) begin
            if (rollback) begin
                busy       <= '0;
                rs_full_p1 <= 1'b0;
                vld_p1     <= 1'b0;
            end else begin
                busy       <= busy_nxt;
                rs_full_p1 <= (cnt_nxt >= FULL_MARK);
                vld_p1     <= sel_vld_p0;
                if (sel_vld_p0) begin
                    opcode_p1  <= ent_opcode[sel_idx_p0];
                    func3_p1   <= ent_func3[sel_idx_p0];
                    func1_p1   <= ent_func1[sel_idx_p0];
                    val1_p1    <= ent_op1[sel_idx_p0].val;
                    val2_p1    <= ent_op2[sel_idx_p0].val;
                    imm_p1     <= ent_imm[sel_idx_p0];
                    pc_p1      <= ent_pc[sel_idx_p0];
                    rob_pos_p1 <= ent_rob_pos[sel_idx_p0];
                end
            end
        end
    end

    assign rs.rs_full     = rs_full_p1;
    assign rs.alu_en      = vld_p1;
    assign rs.alu_opcode  = opcode_p1;
    assign rs.alu_func3   = func3_p1;
    assign rs.alu_func1   = func1_p1;
    assign rs.alu_val1    = val1_p1;
    assign rs.alu_val2    = val2_p1;
    assign rs.alu_imm     = imm_p1;
    assign rs.alu_pc      = pc_p1;
    assign rs.alu_rob_pos = rob_pos_p1;
endmodule
